traffic_ctrl_fsm: RTL

Intersection sequencing state machine for a main road and a side road. It is the consumer of the interval timer's `short_timeout` and `long_timeout` outputs and the source of that timer's `timer_hw_reset`. It restarts the timer on every phase change, advances phases on timeout levels, and drives one-hot lamp outputs plus a pedestrian WALK indication.

---
 rtl/traffic_ctrl_fsm_if.sv | 36 +++
 rtl/traffic_ctrl_fsm.sv | 114 +++++++++++
 2 files changed

// File: rtl/traffic_ctrl_fsm_if.sv
// Timer, sensor and lamp signals of the intersection controller.
// The master side is the controller; the slave side is the timer, sensors and lamps.
interface traffic_ctrl_fsm_if;
    localparam int unsigned LAMP_W = 3;

    logic              short_timeout;
    logic              long_timeout;
    logic              car_side;
    logic              walk_req;
    logic              timer_hw_reset;
    logic [LAMP_W-1:0] main_lt;
    logic [LAMP_W-1:0] side_lt;
    logic              walk;

    modport master (
        input  short_timeout,
        input  long_timeout,
        input  car_side,
        input  walk_req,
        output timer_hw_reset,
        output main_lt,
        output side_lt,
        output walk
    );

    modport slave (
        output short_timeout,
        output long_timeout,
        output car_side,
        output walk_req,
        input  timer_hw_reset,
        input  main_lt,
        input  side_lt,
        input  walk
    );
endinterface

// File: rtl/traffic_ctrl_fsm.sv
// Main/side road intersection sequencer: restarts the interval timer on each phase
// change, advances on timeout levels, and drives one-hot lamps plus the WALK lamp.
module traffic_ctrl_fsm (
    input  logic               clk,
    input  logic               reset,
    traffic_ctrl_fsm_if.master bus
);
    localparam int unsigned ST_W   = 3;
    localparam int unsigned LAMP_W = 3;

    localparam logic [ST_W-1:0] ST_MG  = 3'd0;
    localparam logic [ST_W-1:0] ST_MY  = 3'd1;
    localparam logic [ST_W-1:0] ST_AR1 = 3'd2;
    localparam logic [ST_W-1:0] ST_SG  = 3'd3;
    localparam logic [ST_W-1:0] ST_SY  = 3'd4;
    localparam logic [ST_W-1:0] ST_AR2 = 3'd5;

    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

    logic [ST_W-1:0]   state_q, state_d;
    logic              walk_pend_q, walk_pend_d;
    logic              walk_act_q, walk_act_d;
    logic              timer_hw_reset_q, timer_hw_reset_d;
    logic [LAMP_W-1:0] main_lt_q, main_lt_d;
    logic [LAMP_W-1:0] side_lt_q, side_lt_d;
    logic              walk_q, walk_d;

    logic short_ok;
    logic long_ok;
    logic enter_sg;
    logic leave_sg;

    // The timer still shows the previous phase's count while the restart pulse is out.
    always_comb begin
        short_ok = bus.short_timeout & ~timer_hw_reset_q;
        long_ok  = bus.long_timeout  & ~timer_hw_reset_q;
    end

    // Phase sequencing; illegal codes recover to MG.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MG:   if (long_ok && (bus.car_side || walk_pend_q)) state_d = ST_MY;
            ST_MY:   if (short_ok) state_d = ST_AR1;
            ST_AR1:  if (short_ok) state_d = ST_SG;
            ST_SG:   if (long_ok || (short_ok && !bus.car_side && !walk_act_q)) state_d = ST_SY;
            ST_SY:   if (short_ok) state_d = ST_AR2;
            ST_AR2:  if (short_ok) state_d = ST_MG;
            default: state_d = ST_MG;
        endcase
    end

    // Pedestrian bookkeeping and timer restart.
    always_comb begin
        enter_sg = (state_d == ST_SG) && (state_q != ST_SG);
        leave_sg = (state_q == ST_SG) && (state_d != ST_SG);

        walk_pend_d = walk_pend_q | bus.walk_req;
        if (enter_sg) walk_pend_d = 1'b0;

        walk_act_d = walk_act_q;
        if (enter_sg) begin
            walk_act_d = walk_pend_q | bus.walk_req;
        end else if (leave_sg) begin
            walk_act_d = 1'b0;
        end

        timer_hw_reset_d = (state_d != state_q);
        walk_d           = (state_d == ST_SG) && walk_act_d;
    end

    // Lamp decode from the next state so lamps register on the same edge as the state.
    always_comb begin
        main_lt_d = LAMP_RED;
        side_lt_d = LAMP_RED;
        case (state_d)
            ST_MG:   main_lt_d = LAMP_GRN;
            ST_MY:   main_lt_d = LAMP_YEL;
            ST_SG:   side_lt_d = LAMP_GRN;
            ST_SY:   side_lt_d = LAMP_YEL;
            default: begin
                main_lt_d = LAMP_RED;
                side_lt_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_MG;
            walk_pend_q      <= 1'b0;
            walk_act_q       <= 1'b0;
            timer_hw_reset_q <= 1'b1;
            main_lt_q        <= LAMP_GRN;
            side_lt_q        <= LAMP_RED;
            walk_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            walk_pend_q      <= walk_pend_d;
            walk_act_q       <= walk_act_d;
            timer_hw_reset_q <= timer_hw_reset_d;
            main_lt_q        <= main_lt_d;
            side_lt_q        <= side_lt_d;
            walk_q           <= walk_d;
        end
    end

    assign bus.timer_hw_reset = timer_hw_reset_q;
    assign bus.main_lt        = main_lt_q;
    assign bus.side_lt        = side_lt_q;
    assign bus.walk           = walk_q;
endmodule
